// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and byte-lane helpers for the memory port
//               arbiter: data/address types, memory operation encoding,
//               arbiter state and owner enums, and the byte-enable,
//               store-lane, load-extract and misalignment functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

   localparam int WIDTH = 32;

   typedef logic [WIDTH-1:0] addr_t;
   typedef logic [WIDTH-1:0] data_t;

   // op[1:0] is the access size, op[2] selects zero extension on loads
   typedef enum logic [2:0] {
      MEM_B  = 3'b000,
      MEM_H  = 3'b001,
      MEM_W  = 3'b010,
      MEM_BU = 3'b100,
      MEM_HU = 3'b101
   } mem_op_t;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_t;

   // Byte enables for an access of size op at byte offset a
   function automatic logic [3:0] mem_be(mem_op_t op, logic [1:0] a);
      logic [3:0] be;
      case (op)
         MEM_B, MEM_BU: be = 4'b0001 << a;
         MEM_H, MEM_HU: be = 4'b0011 << a;
         default:       be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicate right-aligned store data into every lane it may land in
   function automatic data_t mem_wlane(mem_op_t op, data_t d);
      data_t w;
      case (op)
         MEM_B, MEM_BU: w = {4{d[7:0]}};
         MEM_H, MEM_HU: w = {2{d[15:0]}};
         default:       w = d;
      endcase
      return w;
   endfunction

   // Pick the addressed byte/half out of a read word and extend it
   function automatic data_t mem_extract(mem_op_t op, logic [1:0] a, data_t d);
      logic [7:0]  b;
      logic [15:0] h;
      data_t       r;
      b = d[{a, 3'b000} +: 8];
      h = a[1] ? d[31:16] : d[15:0];
      case (op)
         MEM_B:   r = {{24{b[7]}}, b};
         MEM_BU:  r = {24'd0, b};
         MEM_H:   r = {{16{h[15]}}, h};
         MEM_HU:  r = {16'd0, h};
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic mem_misaligned(mem_op_t op, logic [1:0] a);
      logic m;
      case (op)
         MEM_B, MEM_BU: m = 1'b0;
         MEM_H, MEM_HU: m = a[0];
         default:       m = (a != 2'b00);
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one external memory port between instruction fetch
//               (word reads) and data access (loads/stores). One transaction
//               in flight; data has priority, with a starvation guard that
//               hands the port to a waiting fetch after MAX_DATA_BURST data
//               grants.
// Ports       : clk, rst              - clock, async active-high reset
//               if_req_* / if_rsp_*   - fetch request / response
//               d_req_*  / d_rsp_*    - data request / response (+ error)
//               bus_*                 - external memory request / response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req_valid,
   output logic             if_req_ready,
   input  logic [WIDTH-1:0] if_req_addr,
   output logic             if_rsp_valid,
   output logic [WIDTH-1:0] if_rsp_data,
   input  logic             d_req_valid,
   output logic             d_req_ready,
   input  logic [WIDTH-1:0] d_req_addr,
   input  logic             d_req_we,
   input  logic [2:0]       d_req_op,
   input  logic [WIDTH-1:0] d_req_wdata,
   output logic             d_rsp_valid,
   output logic [WIDTH-1:0] d_rsp_data,
   output logic             d_rsp_err,
   output logic             bus_req_valid,
   input  logic             bus_req_ready,
   output logic [WIDTH-1:0] bus_addr,
   output logic             bus_we,
   output logic [3:0]       bus_be,
   output logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_rsp_valid,
   input  logic [WIDTH-1:0] bus_rsp_data
);

   localparam logic [3:0] C_STARVE_MAX = 4'(MAX_DATA_BURST);
   localparam addr_t      C_WORD_MASK  = ~addr_t'(3);

   arb_state_t r_state, w_state_nxt;
   owner_t     r_owner;
   addr_t      r_addr;
   logic       r_we;
   mem_op_t    r_op;
   logic [1:0] r_off;
   logic [3:0] r_be;
   data_t      r_wdata;
   logic [3:0] r_starve;

   logic       r_if_rsp_valid;
   data_t      r_if_rsp_data;
   logic       r_d_rsp_valid;
   data_t      r_d_rsp_data;
   logic       r_d_rsp_err;

   logic       w_if_ready;
   logic       w_d_ready;
   mem_op_t    w_d_op;
   logic       w_d_mis;
   logic       w_fetch_turn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ARB_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_if_ready   = 1'b0;
      w_d_ready    = 1'b0;
      w_d_op       = mem_op_t'(d_req_op);
      w_d_mis      = mem_misaligned(w_d_op, d_req_addr[1:0]);
      w_fetch_turn = if_req_valid && (r_starve == C_STARVE_MAX);
      case (r_state)
         ARB_IDLE: begin
            // The cycle carrying a misalignment error response is not
            // available for arbitration.
            if (!r_d_rsp_err) begin
               if (d_req_valid && !w_fetch_turn) begin
                  w_d_ready = 1'b1;
                  // A misaligned access never reaches the bus
                  if (!w_d_mis) w_state_nxt = ARB_ISSUE;
               end else if (if_req_valid) begin
                  w_if_ready  = 1'b1;
                  w_state_nxt = ARB_ISSUE;
               end
            end
         end
         ARB_ISSUE: if (bus_req_ready) w_state_nxt = ARB_WAIT;
         ARB_WAIT:  if (bus_rsp_valid) w_state_nxt = ARB_IDLE;
         default:   w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner        <= OWN_IF;
         r_addr         <= '0;
         r_we           <= 1'b0;
         r_op           <= MEM_W;
         r_off          <= 2'b00;
         r_be           <= 4'b0000;
         r_wdata        <= '0;
         r_starve       <= 4'd0;
         r_if_rsp_valid <= 1'b0;
         r_if_rsp_data  <= '0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rsp_data   <= '0;
         r_d_rsp_err    <= 1'b0;
      end else begin
         r_if_rsp_valid <= 1'b0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rsp_err    <= 1'b0;

         if (w_d_ready) begin
            if (w_d_mis) begin
               r_d_rsp_valid <= 1'b1;
               r_d_rsp_err   <= 1'b1;
               r_d_rsp_data  <= '0;
            end else begin
               r_owner <= OWN_D;
               r_addr  <= d_req_addr & C_WORD_MASK;
               r_off   <= d_req_addr[1:0];
               r_we    <= d_req_we;
               r_op    <= w_d_op;
               r_be    <= mem_be(w_d_op, d_req_addr[1:0]);
               r_wdata <= mem_wlane(w_d_op, d_req_wdata);
            end
         end else if (w_if_ready) begin
            r_owner <= OWN_IF;
            r_addr  <= if_req_addr & C_WORD_MASK;
            r_off   <= 2'b00;
            r_we    <= 1'b0;
            r_op    <= MEM_W;
            r_be    <= 4'b1111;
            r_wdata <= '0;
         end

         // Starvation counter: counts data grants made over a waiting fetch
         if (w_d_ready && if_req_valid) begin
            if (r_starve != C_STARVE_MAX) r_starve <= r_starve + 4'd1;
         end else if (w_if_ready) begin
            r_starve <= 4'd0;
         end

         if (r_state == ARB_WAIT && bus_rsp_valid) begin
            if (r_owner == OWN_IF) begin
               r_if_rsp_valid <= 1'b1;
               r_if_rsp_data  <= bus_rsp_data;
            end else begin
               r_d_rsp_valid <= 1'b1;
               r_d_rsp_data  <= r_we ? '0 : mem_extract(r_op, r_off, bus_rsp_data);
            end
         end
      end
   end

   assign if_req_ready  = w_if_ready;
   assign d_req_ready   = w_d_ready;
   assign if_rsp_valid  = r_if_rsp_valid;
   assign if_rsp_data   = r_if_rsp_data;
   assign d_rsp_valid   = r_d_rsp_valid;
   assign d_rsp_data    = r_d_rsp_data;
   assign d_rsp_err     = r_d_rsp_err;
   assign bus_req_valid = (r_state == ARB_ISSUE);
   assign bus_addr      = r_addr;
   assign bus_we        = r_we;
   assign bus_be        = r_be;
   assign bus_wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. Expected bus requests
//               and responses are queued when stimulus is issued and popped
//               when the DUT produces them; a simple memory model answers
//               bus requests with rd_word one cycle after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int BURST = 4;

   logic        clk, rst;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_req_addr, if_rsp_data;
   logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_err;
   logic [2:0]  d_req_op;
   logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
   logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr, bus_wdata, rd_word;

   mem_port_arbiter #(.MAX_DATA_BURST(BURST)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_we(d_req_we), .d_req_op(d_req_op), .d_req_wdata(d_req_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
      .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(rd_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } rsp_exp_t;

   bus_exp_t    bq[$];
   rsp_exp_t    dq[$];
   logic [31:0] iq[$];

   // ---------------- reference model ----------------
   function automatic logic exp_mis(logic [2:0] op, logic [1:0] a);
      if (op[1:0] == 2'b01) return a[0];
      if (op[1:0] == 2'b00) return 1'b0;
      return a != 2'b00;
   endfunction

   function automatic logic [3:0] exp_be(logic [2:0] op, logic [1:0] a);
      logic [3:0] be;
      be = 4'b0000;
      if (op[1:0] == 2'b00) be[a] = 1'b1;
      else if (op[1:0] == 2'b01) begin be[a] = 1'b1; be[a + 2'd1] = 1'b1; end
      else be = 4'b1111;
      return be;
   endfunction

   function automatic logic [31:0] exp_wd(logic [2:0] op, logic [31:0] wd);
      if (op[1:0] == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      if (op[1:0] == 2'b01) return {wd[15:0], wd[15:0]};
      return wd;
   endfunction

   function automatic logic [31:0] exp_load(logic [2:0] op, logic [1:0] a, logic [31:0] w);
      logic [7:0]  lane [4];
      logic [15:0] h;
      logic [31:0] r;
      for (int k = 0; k < 4; k++) lane[k] = w[8*k +: 8];
      r = w;
      if (op[1:0] == 2'b00)
         r = op[2] ? {24'h0, lane[a]} : {{24{lane[a][7]}}, lane[a]};
      else if (op[1:0] == 2'b01) begin
         h = {lane[a + 2'd1], lane[a]};
         r = op[2] ? {16'h0, h} : {{16{h[15]}}, h};
      end
      return r;
   endfunction

   // ---------------- memory model and monitors ----------------
   int          cyc = 0;
   int          if_rsp_cyc, d_rsp_cyc, n_drsp, ngrant;
   int          if_acc_cyc, d_acc_cyc;
   logic [15:0] glog;
   logic        rsp_en, rsp_due, stray;
   bus_exp_t    mb;
   rsp_exp_t    mr;
   logic [31:0] mi;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      if_rsp_cyc = 0; d_rsp_cyc = 0; n_drsp = 0; ngrant = 0;
      glog = '0; rsp_due = 1'b0;
   end

   always @(negedge clk) begin
      rsp_due = 1'b0;
      if (bus_req_valid && bus_req_ready) begin
         rsp_due = rsp_en;
         if (bq.size() == 0) check("bus_unexpected", 1, 0);
         else begin
            mb = bq.pop_front();
            check("bus_addr", bus_addr, mb.addr);
            check("bus_we", bus_we, mb.we);
            check("bus_be", bus_be, mb.be);
            if (mb.we) check("bus_wdata", bus_wdata, mb.wdata);
         end
      end
      if (if_rsp_valid) begin
         if_rsp_cyc = cyc;
         if (iq.size() == 0) check("if_rsp_unexpected", 1, 0);
         else begin
            mi = iq.pop_front();
            check("if_rsp_data", if_rsp_data, mi);
         end
      end
      if (d_rsp_valid) begin
         d_rsp_cyc = cyc;
         n_drsp++;
         if (dq.size() == 0) check("d_rsp_unexpected", 1, 0);
         else begin
            mr = dq.pop_front();
            check("d_rsp_data", d_rsp_data, mr.data);
            check("d_rsp_err", d_rsp_err, mr.err);
         end
      end
      if (d_req_valid && d_req_ready) begin glog = {glog[14:0], 1'b1}; ngrant++; end
      else if (if_req_valid && if_req_ready) begin glog = {glog[14:0], 1'b0}; ngrant++; end
   end

   always @(posedge clk) begin
      #1;
      bus_rsp_valid = rsp_due | stray;
   end

   // ---------------- stimulus tasks ----------------
   task automatic push_d(input logic [31:0] a, input logic we, input logic [2:0] op,
                         input logic [31:0] wd);
      bus_exp_t b;
      rsp_exp_t r;
      if (exp_mis(op, a[1:0])) begin
         r.data = 32'h0; r.err = 1'b1;
      end else begin
         b.addr = {a[31:2], 2'b00}; b.we = we; b.be = exp_be(op, a[1:0]); b.wdata = exp_wd(op, wd);
         bq.push_back(b);
         r.data = we ? 32'h0 : exp_load(op, a[1:0], rd_word); r.err = 1'b0;
      end
      dq.push_back(r);
   endtask

   task automatic push_if(input logic [31:0] a);
      bus_exp_t b;
      b.addr = {a[31:2], 2'b00}; b.we = 1'b0; b.be = 4'b1111; b.wdata = 32'h0;
      bq.push_back(b);
      iq.push_back(rd_word);
   endtask

   task automatic send_d(input logic [31:0] a, input logic we, input logic [2:0] op,
                         input logic [31:0] wd);
      int t;
      d_req_valid = 1'b1; d_req_addr = a; d_req_we = we; d_req_op = op; d_req_wdata = wd;
      t = 0;
      @(negedge clk);
      while (!d_req_ready && t < 50) begin @(negedge clk); t++; end
      if (!d_req_ready) check("d_accept_timeout", t, 0);
      d_acc_cyc = cyc;
      @(posedge clk); #1;
      d_req_valid = 1'b0;
   endtask

   task automatic send_if(input logic [31:0] a);
      int t;
      if_req_valid = 1'b1; if_req_addr = a;
      t = 0;
      @(negedge clk);
      while (!if_req_ready && t < 50) begin @(negedge clk); t++; end
      if (!if_req_ready) check("if_accept_timeout", t, 0);
      if_acc_cyc = cyc;
      @(posedge clk); #1;
      if_req_valid = 1'b0;
   endtask

   task automatic do_d(input logic [31:0] a, input logic we, input logic [2:0] op,
                       input logic [31:0] wd);
      push_d(a, we, op, wd);
      send_d(a, we, op, wd);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((bq.size() != 0 || dq.size() != 0 || iq.size() != 0) && t < 100) begin
         @(negedge clk); t++;
      end
      if (t >= 100) check("drain_timeout", t, 0);
      @(posedge clk); #1;
   endtask

   // ---------------- test sequence ----------------
   int g0, snap;

   initial begin
      rst = 1'b1; rsp_en = 1'b1; stray = 1'b0; rd_word = 32'h0;
      if_req_valid = 1'b0; if_req_addr = '0;
      d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0; d_req_op = 3'b010; d_req_wdata = '0;
      bus_req_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bus_req_valid", bus_req_valid, 0);
      check("rst_bus_be", bus_be, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_d_rsp_valid", d_rsp_valid, 0);
      check("rst_if_rsp_valid", if_rsp_valid, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // fetch only
      rd_word = 32'h0000_0013;
      push_if(32'h100);
      send_if(32'h100);
      drain();
      check("if_latency", if_rsp_cyc - if_acc_cyc, 3);

      // simultaneous data and fetch: data first
      rd_word = 32'h1234_5678;
      push_d(32'h200, 1'b0, MEM_W, 32'h0);
      push_if(32'h180);
      fork
         send_d(32'h200, 1'b0, MEM_W, 32'h0);
         send_if(32'h180);
      join
      drain();
      check("simul_order", {30'h0, glog[1:0]}, 32'b10);

      // stores and loads of every size
      do_d(32'h203, 1'b1, MEM_B, 32'h0000_00AB); drain();
      do_d(32'h206, 1'b1, MEM_H, 32'h0000_BEEF); drain();
      do_d(32'h204, 1'b1, MEM_W, 32'hCAFE_F00D); drain();
      rd_word = 32'h0000_F000;
      do_d(32'h201, 1'b0, MEM_B,  32'h0); drain();
      check("lb_latency", d_rsp_cyc - d_acc_cyc, 3);
      do_d(32'h201, 1'b0, MEM_BU, 32'h0); drain();
      rd_word = 32'h8001_0000;
      do_d(32'h202, 1'b0, MEM_H,  32'h0); drain();
      do_d(32'h202, 1'b0, MEM_HU, 32'h0); drain();

      // misaligned load with fetch waiting: error next cycle, no bus access,
      // fetch granted only after the error cycle
      rd_word = 32'h0000_0033;
      push_d(32'h202, 1'b0, MEM_W, 32'h0);
      push_if(32'h400);
      fork
         send_d(32'h202, 1'b0, MEM_W, 32'h0);
         send_if(32'h400);
      join
      drain();
      check("mis_latency", d_rsp_cyc - d_acc_cyc, 1);
      check("mis_blocks_arb", if_acc_cyc - d_acc_cyc, 2);

      // bus stall: request held stable, misaligned fetch forced aligned
      bus_req_ready = 1'b0;
      rd_word = 32'h0000_0067;
      push_if(32'h105);
      send_if(32'h105);
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", bus_req_valid, 1);
         check("stall_addr", bus_addr, 32'h104);
      end
      @(posedge clk); #1;
      bus_req_ready = 1'b1;
      drain();

      // starvation guard: D,D,D,D,F,D,D
      rd_word = 32'h1122_3344;
      for (int i = 0; i < 4; i++) push_d(32'h500 + 32'(4*i), 1'b0, MEM_W, 32'h0);
      push_if(32'h600);
      for (int i = 4; i < 6; i++) push_d(32'h500 + 32'(4*i), 1'b0, MEM_W, 32'h0);
      g0 = ngrant;
      fork
         for (int i = 0; i < 6; i++) send_d(32'h500 + 32'(4*i), 1'b0, MEM_W, 32'h0);
         send_if(32'h600);
      join
      drain();
      check("burst_ngrant", ngrant - g0, 7);
      check("burst_order", {25'h0, glog[6:0]}, 32'b1111011);

      // reset during WAIT, then a stray response
      rsp_en = 1'b0;
      rd_word = 32'h0BAD_0BAD;
      bq.push_back('{addr: 32'h300, we: 1'b0, be: 4'hF, wdata: 32'h0});
      send_d(32'h300, 1'b0, MEM_W, 32'hDEAD_BEEF);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_bus_req_valid", bus_req_valid, 0);
      check("arst_bus_we", bus_we, 0);
      check("arst_bus_be", bus_be, 0);
      check("arst_bus_addr", bus_addr, 0);
      check("arst_bus_wdata", bus_wdata, 0);
      check("arst_d_rsp_data", d_rsp_data, 0);
      check("arst_if_rsp_data", if_rsp_data, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_en = 1'b1;
      snap = n_drsp;
      @(negedge clk); stray = 1'b1;
      @(negedge clk); stray = 1'b0;
      repeat (4) @(negedge clk);
      check("stray_rsp", n_drsp - snap, 0);

      // recovery
      @(posedge clk); #1;
      rd_word = 32'h0000_0093;
      push_if(32'h700);
      send_if(32'h700);
      drain();

      check("bq_empty", bq.size(), 0);
      check("dq_empty", dq.size(), 0);
      check("iq_empty", iq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
